// File: rtl/mux_4to1.sv
// 4-to-1 selector steering one of A/B/C/D onto Y under control of S.
// Y is either registered (1-cycle latency, synchronous active-low reset) or purely combinational.
`timescale 1ns/1ps
module mux_4to1 #(
  parameter int                 WIDTH      = 1,
  parameter bit                 REGISTERED = 1'b1,
  parameter logic [WIDTH-1:0]   RESET_VAL  = '0
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [WIDTH-1:0] D,
  input  logic [1:0]       S,
  output logic [WIDTH-1:0] Y,
  input  logic             clk,
  input  logic             rst_n
);

  logic [WIDTH-1:0] y_d;

  // Each bit gets its own 4:1 tree so the select fans out cleanly per lane.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    assign y_d[gi] = S[1] ? (S[0] ? D[gi] : C[gi])
                          : (S[0] ? B[gi] : A[gi]);
  end

  if (REGISTERED) begin : g_reg
    logic [WIDTH-1:0] y_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        y_q <= RESET_VAL;
      end else begin
        y_q <= y_d;
      end
    end

    assign Y = y_q;
  end else begin : g_comb
    // Clock and reset have no function in the combinational build.
    logic unused_clk_rst;
    assign unused_clk_rst = &{1'b0, clk, rst_n};
    assign Y = y_d;
  end

endmodule

// File: tb/tb_mux_4to1.sv
// Self-checking bench for mux_4to1: registered 1-bit and 8-bit instances plus a combinational 4-bit one.
`timescale 1ns/1ps
module tb_mux_4to1;

  logic       clk;
  logic       rst_n;

  logic       a, b, c, d;
  logic [1:0] s;
  logic       y;

  logic [3:0] a4, b4, c4, d4;
  logic [1:0] s4;
  logic [3:0] y4;

  logic [7:0] a8, b8, c8, d8;
  logic [1:0] s8;
  logic [7:0] y8;

  int total;
  int bad;

  logic       sb1[$];
  logic [3:0] sb4[$];
  logic [7:0] sb8[$];

  mux_4to1 dut1 (
    .A(a), .B(b), .C(c), .D(d), .S(s), .Y(y), .clk(clk), .rst_n(rst_n)
  );

  mux_4to1 #(.WIDTH(4), .REGISTERED(1'b0)) dut4 (
    .A(a4), .B(b4), .C(c4), .D(d4), .S(s4), .Y(y4), .clk(clk), .rst_n(rst_n)
  );

  mux_4to1 #(.WIDTH(8), .REGISTERED(1'b1), .RESET_VAL(8'hA5)) dut8 (
    .A(a8), .B(b8), .C(c8), .D(d8), .S(s8), .Y(y8), .clk(clk), .rst_n(rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    logic exp1;
    logic [7:0] exp8;
    a = 1; b = 1; c = 1; d = 1; s = 2'b00;
    a8 = 8'h11; b8 = 8'h22; c8 = 8'h33; d8 = 8'h44; s8 = 2'b00;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      rst_n = 1'b0;
      sb1.push_back(1'b0);
      sb8.push_back(8'hA5);
      @(posedge clk); #1;
      exp1 = sb1.pop_front();
      exp8 = sb8.pop_front();
      total++;
      if (y !== exp1) begin
        bad++;
        $display("FAIL reset_y%0d: got %b expected %b", i, y, exp1);
      end else $display("reset edge %0d: y=%b", i, y);
      total++;
      if (y8 !== exp8) begin
        bad++;
        $display("FAIL reset_y8_%0d: got %h expected %h", i, y8, exp8);
      end else $display("reset edge %0d: y8=%h", i, y8);
    end
    @(negedge clk);
    rst_n = 1'b1;
    s = 2'b00;
    sb1.push_back(1'b1);
    #1;
    total++;
    if (y !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold: got %b expected 0 before edge", y);
    end else $display("release pre-edge: y=%b", y);
    @(posedge clk); #1;
    exp1 = sb1.pop_front();
    total++;
    if (y !== exp1) begin
      bad++;
      $display("FAIL reset_release: got %b expected %b", y, exp1);
    end else $display("release edge: y=%b", y);
  endtask

  task automatic test_sweep(input logic pa, input logic pb, input logic pc, input logic pd);
    logic exp1;
    logic prev;
    logic [3:0] vals;
    vals = {pd, pc, pb, pa};
    @(negedge clk);
    a = pa; b = pb; c = pc; d = pd;
    for (int i = 0; i < 4; i++) begin
      if (i != 0) @(negedge clk);
      prev = y;
      s = 2'(i);
      sb1.push_back(vals[i]);
      #1;
      total++;
      if (y !== prev) begin
        bad++;
        $display("FAIL sweep_hold s=%0d: got %b expected %b", i, y, prev);
      end
      @(posedge clk); #1;
      exp1 = sb1.pop_front();
      total++;
      if (y !== exp1) begin
        bad++;
        $display("FAIL sweep s=%0d data=%b: got %b expected %b", i, vals, y, exp1);
      end else $display("sweep data=%b s=%0d: y=%b", vals, i, y);
    end
  endtask

  task automatic test_glitch();
    logic exp1;
    @(negedge clk);
    s = 2'b10; c = 1'b0; a = 1; b = 1; d = 1;
    sb1.push_back(1'b0);
    @(posedge clk); #1;
    exp1 = sb1.pop_front();
    total++;
    if (y !== exp1) begin
      bad++;
      $display("FAIL glitch_setup: got %b expected %b", y, exp1);
    end else $display("glitch setup: y=%b", y);
    @(negedge clk);
    c = 1'b1; #1;
    c = 1'b0; #1;
    c = 1'b1;
    sb1.push_back(1'b1);
    #1;
    total++;
    if (y !== 1'b0) begin
      bad++;
      $display("FAIL glitch_midcycle: got %b expected 0", y);
    end else $display("glitch mid-cycle: y=%b", y);
    @(posedge clk); #1;
    exp1 = sb1.pop_front();
    total++;
    if (y !== exp1) begin
      bad++;
      $display("FAIL glitch_edge: got %b expected %b", y, exp1);
    end else $display("glitch edge: y=%b", y);
  endtask

  task automatic test_reset_midstream();
    logic exp1;
    logic [2:0] rst_seq;
    logic [2:0] exp_seq;
    rst_seq = 3'b101;
    exp_seq = 3'b101;
    @(negedge clk);
    s = 2'b11; d = 1'b1; a = 0; b = 0; c = 0;
    for (int i = 0; i < 3; i++) begin
      if (i != 0) @(negedge clk);
      rst_n = rst_seq[i];
      sb1.push_back(exp_seq[i]);
      @(posedge clk); #1;
      exp1 = sb1.pop_front();
      total++;
      if (y !== exp1) begin
        bad++;
        $display("FAIL midreset step%0d rst_n=%b: got %b expected %b", i, rst_seq[i], y, exp1);
      end else $display("midreset step%0d rst_n=%b: y=%b", i, rst_seq[i], y);
    end
  endtask

  task automatic test_comb();
    logic [3:0] exp4;
    logic [3:0] tbl [4];
    tbl[0] = 4'h3; tbl[1] = 4'hC; tbl[2] = 4'h5; tbl[3] = 4'hA;
    a4 = 4'h3; b4 = 4'hC; c4 = 4'h5; d4 = 4'hA;
    for (int i = 0; i < 4; i++) begin
      s4 = 2'(i);
      sb4.push_back(tbl[i]);
      #1;
      exp4 = sb4.pop_front();
      total++;
      if (y4 !== exp4) begin
        bad++;
        $display("FAIL comb s=%0d: got %h expected %h", i, y4, exp4);
      end else $display("comb s=%0d: y4=%h", i, y4);
    end
    c4 = 4'h9;
    s4 = 2'b10;
    sb4.push_back(4'h9);
    #1;
    exp4 = sb4.pop_front();
    total++;
    if (y4 !== exp4) begin
      bad++;
      $display("FAIL comb_data_change: got %h expected %h", y4, exp4);
    end else $display("comb data change: y4=%h", y4);
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp8;
    logic [7:0] m;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rst_n = 1'b1;
      a8 = 8'($urandom); b8 = 8'($urandom); c8 = 8'($urandom); d8 = 8'($urandom);
      s8 = 2'($urandom_range(0, 3));
      case (s8)
        2'b00:   m = a8;
        2'b01:   m = b8;
        2'b10:   m = c8;
        default: m = d8;
      endcase
      sb8.push_back(m);
      @(posedge clk); #1;
      exp8 = sb8.pop_front();
      total++;
      if (y8 !== exp8) begin
        bad++;
        $display("FAIL stream8 #%0d s=%0d: got %h expected %h", i, s8, y8, exp8);
      end else $display("stream8 #%0d s=%0d: y8=%h", i, s8, y8);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    a = 0; b = 0; c = 0; d = 0; s = 2'b00;
    a4 = 0; b4 = 0; c4 = 0; d4 = 0; s4 = 2'b00;
    a8 = 0; b8 = 0; c8 = 0; d8 = 0; s8 = 2'b00;

    test_reset();
    test_sweep(1'b0, 1'b1, 1'b0, 1'b1);
    test_sweep(1'b1, 1'b0, 1'b1, 1'b0);
    test_glitch();
    test_reset_midstream();
    test_comb();
    test_back_to_back();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
